// File: rtl/image_frame_buffer.sv
// image_frame_buffer: packs pixel beats into binary frames with optional ping-pong storage released by consumer ack.
module image_frame_buffer #(
  parameter int IMG_W      = 14,
  parameter int IMG_H      = 14,
  parameter int BEAT_W     = 7,
  parameter int DOUBLE_BUF = 1,
  localparam int PIX       = IMG_W * IMG_H,
  localparam int BEATS     = PIX / BEAT_W,
  localparam int CW        = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_data,
  output logic              in_ready,
  output logic              frame_valid,
  output logic [PIX-1:0]    frame_data,
  input  logic              frame_ack,
  output logic [CW-1:0]     beat_idx,
  output logic [7:0]        frame_cnt,
  output logic              overflow
);
  typedef enum logic {FILL, BLOCKED} state_t;
  state_t         state;
  logic [1:0]     full, full_nxt;
  logic           wr_slot, rd_slot, wr_nxt;
  logic [PIX-1:0] mem [2];
  logic           acc, last, ack_ok;
  assign in_ready    = state == FILL;
  assign acc         = in_valid && in_ready && !frame_start;
  assign last        = acc && beat_idx == CW'(BEATS - 1);
  assign ack_ok      = frame_ack && full[rd_slot];
  assign frame_valid = full[rd_slot];
  assign frame_data  = full[rd_slot] ? mem[rd_slot] : '0;
  // Commit and release can land on the same edge; the next state follows whether the new write slot is free.
  always_comb begin
    full_nxt = full;
    if (last) full_nxt[wr_slot] = 1'b1;
    if (ack_ok) full_nxt[rd_slot] = 1'b0;
    wr_nxt = (last && DOUBLE_BUF != 0) ? ~wr_slot : wr_slot;
  end
  always_ff @(posedge clk)
    if (acc) mem[wr_slot][beat_idx*BEAT_W +: BEAT_W] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= FILL;
      full      <= '0;
      wr_slot   <= 1'b0;
      rd_slot   <= 1'b0;
      beat_idx  <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= full_nxt[wr_nxt] ? BLOCKED : FILL;
      full      <= full_nxt;
      wr_slot   <= wr_nxt;
      rd_slot   <= (ack_ok && DOUBLE_BUF != 0) ? ~rd_slot : rd_slot;
      beat_idx  <= frame_start ? '0 : last ? '0 : acc ? beat_idx + CW'(1) : beat_idx;
      frame_cnt <= last ? frame_cnt + 8'd1 : frame_cnt;
      overflow  <= frame_start ? 1'b0 : overflow | (in_valid && !in_ready);
    end
endmodule

// File: tb/tb_image_frame_buffer.sv
// tb_image_frame_buffer: directed checks of the default ping-pong buffer and a 4x4 single-slot variant.
`timescale 1ns/1ps
module tb_image_frame_buffer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic fs0 = 0, iv0 = 0, ack0 = 0, ir0, fv0, ov0;
  logic [6:0] id0 = 0;
  logic [195:0] fd0;
  logic [4:0] bi0;
  logic [7:0] fc0;
  logic fs1 = 0, iv1 = 0, ack1 = 0, ir1, fv1, ov1;
  logic [3:0] id1 = 0;
  logic [15:0] fd1;
  logic [1:0] bi1;
  logic [7:0] fc1;
  int total = 0, bad = 0;
  logic [195:0] fa, fb;

  image_frame_buffer dut0 (.clk(clk), .rst_n(rst_n), .frame_start(fs0), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .frame_valid(fv0), .frame_data(fd0), .frame_ack(ack0), .beat_idx(bi0),
    .frame_cnt(fc0), .overflow(ov0));
  image_frame_buffer #(.IMG_W(4), .IMG_H(4), .BEAT_W(4), .DOUBLE_BUF(0)) dut1 (.clk(clk), .rst_n(rst_n),
    .frame_start(fs1), .in_valid(iv1), .in_data(id1), .in_ready(ir1), .frame_valid(fv1), .frame_data(fd1),
    .frame_ack(ack1), .beat_idx(bi1), .frame_cnt(fc1), .overflow(ov1));

  task automatic do_reset;
    iv0 = 0; fs0 = 0; ack0 = 0; iv1 = 0; fs1 = 0; ack1 = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic beat0(input logic [6:0] d);
    iv0 = 1; id0 = d;
    @(posedge clk); #1;
    iv0 = 0;
  endtask

  task automatic beat1(input logic [3:0] d);
    iv1 = 1; id1 = d;
    @(posedge clk); #1;
    iv1 = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; #1;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", ir0); end
    total++; if (fv0 !== 1'b0) begin bad++; $display("FAIL rst_frame_valid got=%b exp=0", fv0); end
    total++; if (fd0 !== '0) begin bad++; $display("FAIL rst_frame_data got=%h exp=0", fd0); end
    total++; if (bi0 !== 5'd0) begin bad++; $display("FAIL rst_beat_idx got=%0d exp=0", bi0); end
    total++; if (fc0 !== 8'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", fc0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", ov0); end
    do_reset();
  endtask

  task automatic test_fill;
    for (int k = 0; k < 27; k++) beat0(7'(k));
    total++; if (fv0 !== 1'b0) begin bad++; $display("FAIL fill_early_valid got=%b exp=0", fv0); end
    total++; if (bi0 !== 5'd27) begin bad++; $display("FAIL fill_beat_idx got=%0d exp=27", bi0); end
    beat0(7'd27);
    total++; if (fv0 !== 1'b1) begin bad++; $display("FAIL fill_valid got=%b exp=1", fv0); end
    total++; if (fd0[6:0] !== 7'd0) begin bad++; $display("FAIL fill_beat0 got=%h exp=0", fd0[6:0]); end
    total++; if (fd0[195:189] !== 7'd27) begin bad++; $display("FAIL fill_beat27 got=%0d exp=27", fd0[195:189]); end
    total++; if (fd0 !== fa) begin bad++; $display("FAIL fill_data got=%h exp=%h", fd0, fa); end
    total++; if (fc0 !== 8'd1) begin bad++; $display("FAIL fill_cnt got=%0d exp=1", fc0); end
    total++; if (bi0 !== 5'd0) begin bad++; $display("FAIL fill_wrap got=%0d exp=0", bi0); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b exp=1", ir0); end
    @(posedge clk); #1;
    total++; if (fd0 !== fa) begin bad++; $display("FAIL fill_hold got=%h exp=%h", fd0, fa); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 28; k++) beat0(7'(k) ^ 7'h55);
    total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b exp=0", ir0); end
    total++; if (fd0 !== fa) begin bad++; $display("FAIL b2b_hold_a got=%h exp=%h", fd0, fa); end
    total++; if (fc0 !== 8'd2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=2", fc0); end
    beat0(7'h33);
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL b2b_overflow got=%b exp=1", ov0); end
    total++; if (bi0 !== 5'd0) begin bad++; $display("FAIL b2b_dropped got=%0d exp=0", bi0); end
    fs0 = 1; @(posedge clk); #1; fs0 = 0;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL b2b_ov_clear got=%b exp=0", ov0); end
    total++; if (fv0 !== 1'b1 || fc0 !== 8'd2) begin bad++; $display("FAIL b2b_fs_keep got=%b/%0d exp=1/2", fv0, fc0); end
    ack0 = 1; @(posedge clk); #1; ack0 = 0;
    total++; if (fv0 !== 1'b1) begin bad++; $display("FAIL b2b_ack_valid got=%b exp=1", fv0); end
    total++; if (fd0 !== fb) begin bad++; $display("FAIL b2b_ack_data got=%h exp=%h", fd0, fb); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL b2b_ack_ready got=%b exp=1", ir0); end
    ack0 = 1; @(posedge clk); #1; ack0 = 0;
    total++; if (fv0 !== 1'b0 || fd0 !== '0) begin bad++; $display("FAIL b2b_empty got=%b/%h exp=0/0", fv0, fd0); end
  endtask

  task automatic test_ack_same_cycle;
    do_reset();
    for (int k = 0; k < 28; k++) beat0(7'(k));
    for (int k = 0; k < 27; k++) beat0(7'(k) ^ 7'h55);
    ack0 = 1; beat0(7'd27 ^ 7'h55); ack0 = 0;
    total++; if (fv0 !== 1'b1) begin bad++; $display("FAIL same_valid got=%b exp=1", fv0); end
    total++; if (fd0 !== fb) begin bad++; $display("FAIL same_data got=%h exp=%h", fd0, fb); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL same_ready got=%b exp=1", ir0); end
    total++; if (fc0 !== 8'd2) begin bad++; $display("FAIL same_cnt got=%0d exp=2", fc0); end
  endtask

  task automatic test_frame_start;
    do_reset();
    for (int k = 0; k < 10; k++) beat0(7'(k));
    fs0 = 1; beat0(7'h11); fs0 = 0;
    total++; if (bi0 !== 5'd0) begin bad++; $display("FAIL fs_idx got=%0d exp=0", bi0); end
    total++; if (fv0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL fs_flags got=%b/%b exp=0/0", fv0, ov0); end
    for (int k = 0; k < 28; k++) beat0(7'h7F);
    total++; if (fd0 !== {196{1'b1}}) begin bad++; $display("FAIL fs_ones got=%h exp=all ones", fd0); end
    total++; if (fc0 !== 8'd1) begin bad++; $display("FAIL fs_cnt got=%0d exp=1", fc0); end
  endtask

  task automatic test_single;
    do_reset();
    ack1 = 1; @(posedge clk); #1; ack1 = 0;
    total++; if (fv1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL single_idle_ack got=%b/%b exp=0/1", fv1, ir1); end
    for (int k = 1; k <= 4; k++) beat1(4'(k));
    total++; if (fv1 !== 1'b1 || fd1 !== 16'h4321) begin bad++; $display("FAIL single_frame got=%b/%h exp=1/4321", fv1, fd1); end
    total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL single_blocked got=%b exp=0", ir1); end
    beat1(4'hE);
    total++; if (ov1 !== 1'b1 || fd1 !== 16'h4321) begin bad++; $display("FAIL single_ov got=%b/%h exp=1/4321", ov1, fd1); end
    ack1 = 1; @(posedge clk); #1; ack1 = 0;
    total++; if (fv1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL single_ack got=%b/%b exp=0/1", fv1, ir1); end
    for (int k = 5; k <= 8; k++) beat1(4'(k));
    total++; if (fd1 !== 16'h8765 || fc1 !== 8'd2) begin bad++; $display("FAIL single_second got=%h/%0d exp=8765/2", fd1, fc1); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 15; k++) beat0(7'(k));
    iv0 = 1; id0 = 7'd15; #2; rst_n = 0; #1;
    total++; if (bi0 !== 5'd0 || ir0 !== 1'b1 || fv0 !== 1'b0) begin bad++; $display("FAIL mid_async got=%0d/%b/%b exp=0/1/0", bi0, ir0, fv0); end
    iv0 = 0; @(posedge clk); #1; rst_n = 1;
    for (int k = 0; k < 27; k++) beat0(7'(k));
    total++; if (fv0 !== 1'b0) begin bad++; $display("FAIL mid_early got=%b exp=0", fv0); end
    beat0(7'd27);
    @(posedge clk); #1;
    total++; if (fv0 !== 1'b1 || fc0 !== 8'd1 || fd0 !== fa) begin bad++; $display("FAIL mid_one_frame got=%b/%0d exp=1/1", fv0, fc0); end
  endtask

  initial begin
    for (int k = 0; k < 28; k++) begin
      fa[k*7 +: 7] = 7'(k);
      fb[k*7 +: 7] = 7'(k) ^ 7'h55;
    end
    test_reset();
    test_fill();
    test_back_to_back();
    test_ack_same_cycle();
    test_frame_start();
    test_single();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
